// File: rtl/phase_seq_pkg.sv
// Shared state encodings for the phase sequencer.
// Blocks that decode sequencer state import this package.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter with enable and zero flag.
// The decrement holds at zero so the count never wraps.
module phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] d,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= d;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/phase_seq_sm.sv
// Programmable RUN/WAIT phase sequencer with repeat and abort.
// Define PHASE_SEQ_RETRIG_EN to allow a restart straight from DONE.
module phase_seq_sm
    import phase_seq_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_len,
    input  logic [CNT_W-1:0] wait_len,
    input  logic [REP_W-1:0] rep_cnt,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] iter
);

    state_e           state_q, state_d;
    logic [REP_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] run_q, wait_q;
    logic [REP_W-1:0] rep_q;
    logic             cap;
    logic             ld;
    logic             en;
    logic [CNT_W-1:0] ld_val;
    logic             zero;
    logic             pass_end;

    // A zero run length still yields a single RUN cycle
    function automatic logic [CNT_W-1:0] first_ld(input logic [CNT_W-1:0] l);
        return (l == '0) ? '0 : l - 1'b1;
    endfunction

    phase_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (ld),
        .en   (en),
        .d    (ld_val),
        .zero (zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            run_q   <= '0;
            wait_q  <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            if (cap) begin
                run_q  <= run_len;
                wait_q <= wait_len;
                rep_q  <= rep_cnt;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        cap      = 1'b0;
        ld       = 1'b0;
        en       = 1'b0;
        ld_val   = '0;
        pass_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_RUN;
                    cap     = 1'b1;
                    ld      = 1'b1;
                    ld_val  = first_ld(run_len);
                    iter_d  = '0;
                end
            end
            S_RUN: begin
                en = 1'b1;
                if (zero) begin
                    if (wait_q != '0) begin
                        state_d = S_WAIT;
                        ld      = 1'b1;
                        ld_val  = wait_q - 1'b1;
                    end else begin
                        pass_end = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                en       = 1'b1;
                pass_end = zero;
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef PHASE_SEQ_RETRIG_EN
                if (trigger) begin
                    state_d = S_RUN;
                    cap     = 1'b1;
                    ld      = 1'b1;
                    ld_val  = first_ld(run_len);
                    iter_d  = '0;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (pass_end) begin
            if (iter_q < rep_q) begin
                state_d = S_RUN;
                iter_d  = iter_q + 1'b1;
                ld      = 1'b1;
                ld_val  = first_ld(run_q);
            end else begin
                state_d = S_DONE;
            end
        end

        // Abort overrides every transition, including a start
        if (abort) begin
            state_d = S_IDLE;
            cap     = 1'b0;
            ld      = 1'b0;
            if (state_q != S_IDLE) begin
                iter_d = '0;
            end
        end
    end

    assign state = state_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign iter  = iter_q;

endmodule
